// File: rtl/isa_bus_initiator.sv
// ISA-style bus cycle initiator: sequences address setup, a stretchable strobe and
// hold for one I/O or memory request at a time, then returns read data or a timeout.
module isa_bus_initiator #(
    parameter int         SETUP_CYCLES  = 1,
    parameter int         STROBE_CYCLES = 4,
    parameter int         HOLD_CYCLES   = 1,
    parameter int         WAIT_TIMEOUT  = 255,
    parameter logic [7:0] FLOAT_DATA    = 8'hFF
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [14:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic [14:0] bus_a,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic        bus_aen,
    output logic [7:0]  bus_d,
    input  logic [7:0]  bus_out,
    input  logic        bus_dir,
    input  logic        bus_rdy
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_HOLD} state_t;

    localparam logic [7:0] SETUP_N   = 8'(SETUP_CYCLES);
    localparam logic [7:0] STROBE_N  = 8'(STROBE_CYCLES);
    localparam logic [7:0] HOLD_N    = 8'(HOLD_CYCLES);
    localparam logic [7:0] TIMEOUT_N = 8'(WAIT_TIMEOUT);
    localparam logic [3:0] STRB_OFF  = 4'b1111;

    state_t      state;
    logic [7:0]  cnt;
    logic [7:0]  wcnt;
    logic        cyc_write;
    logic        cyc_io;
    logic [7:0]  pend_rdata;
    logic        pend_tmo;
    logic [3:0]  strb_l;

    logic        end_ok;
    logic        end_tmo;
    logic        strobe_end;
    logic        finish;
    logic [7:0]  cap_rdata;
    logic [7:0]  fin_rdata;
    logic        fin_tmo;

    assign {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l} = strb_l;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Strobe vector order is {ior_l, iow_l, memr_l, memw_l}; exactly one bit low.
    function automatic logic [3:0] strobe_sel(input logic io, input logic wr);
        case ({io, wr})
            2'b10:   return 4'b0111;
            2'b11:   return 4'b1011;
            2'b00:   return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic logic [7:0] read_value(input logic wr, input logic tmo,
                                              input logic dir, input logic [7:0] d);
        if (wr)
            return 8'h00;
        if (tmo || !dir)
            return FLOAT_DATA;
        return d;
    endfunction

    always_comb begin
        end_ok  = 1'b0;
        end_tmo = 1'b0;
        case (state)
            S_STROBE: begin
                if (cnt >= STROBE_N) begin
                    if (bus_rdy)
                        end_ok = 1'b1;
                    else if (TIMEOUT_N == 8'd0)
                        end_tmo = 1'b1;
                end
            end
            S_WAIT: begin
                // A ready slave wins over a timeout landing on the same clock.
                if (bus_rdy)
                    end_ok = 1'b1;
                else if (sat_inc(wcnt) >= TIMEOUT_N)
                    end_tmo = 1'b1;
            end
            default: ;
        endcase
        strobe_end = end_ok | end_tmo;
        cap_rdata  = read_value(cyc_write, end_tmo, bus_dir, bus_out);
        finish     = (strobe_end && (HOLD_N == 8'd0)) || ((state == S_HOLD) && (cnt >= HOLD_N));
        fin_rdata  = (state == S_HOLD) ? pend_rdata : cap_rdata;
        fin_tmo    = (state == S_HOLD) ? pend_tmo : end_tmo;
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            wcnt        <= 8'd0;
            cyc_write   <= 1'b0;
            cyc_io      <= 1'b0;
            pend_rdata  <= 8'h00;
            pend_tmo    <= 1'b0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 8'h00;
            rsp_timeout <= 1'b0;
            bus_a       <= 15'd0;
            bus_d       <= 8'h00;
            bus_aen     <= 1'b1;
            strb_l      <= STRB_OFF;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 8'h00;
            rsp_timeout <= 1'b0;
            if (finish) begin
                // req_ready stays low through the response clock, rising one clock later.
                rsp_valid   <= 1'b1;
                rsp_rdata   <= fin_rdata;
                rsp_timeout <= fin_tmo;
                bus_a       <= 15'd0;
                bus_d       <= 8'h00;
                bus_aen     <= 1'b1;
                strb_l      <= STRB_OFF;
                state       <= S_IDLE;
            end else if (strobe_end) begin
                strb_l     <= STRB_OFF;
                pend_rdata <= cap_rdata;
                pend_tmo   <= end_tmo;
                cnt        <= 8'd1;
                state      <= S_HOLD;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!req_ready) begin
                            req_ready <= 1'b1;
                        end else if (req_valid) begin
                            req_ready <= 1'b0;
                            cyc_write <= req_write;
                            cyc_io    <= req_io;
                            bus_a     <= req_addr;
                            bus_d     <= req_write ? req_wdata : 8'h00;
                            bus_aen   <= 1'b0;
                            cnt       <= 8'd1;
                            state     <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        if (cnt >= SETUP_N) begin
                            strb_l <= strobe_sel(cyc_io, cyc_write);
                            cnt    <= 8'd1;
                            state  <= S_STROBE;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                    S_STROBE: begin
                        if (cnt >= STROBE_N) begin
                            wcnt  <= 8'd0;
                            state <= S_WAIT;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                    S_WAIT:  wcnt <= sat_inc(wcnt);
                    S_HOLD:  cnt  <= sat_inc(cnt);
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_isa_bus_initiator.sv
// Bench for isa_bus_initiator: a per-cycle timeline model of each bus cycle checked
// every clock, plus hand-computed strobe widths, latencies and read data.
module tb_isa_bus_initiator;

    localparam int S  = 1;
    localparam int T  = 4;
    localparam int H  = 1;
    localparam int TO = 10;

    logic        clk = 1'b0;
    logic        nRESET;
    logic        req_valid, req_ready, req_write, req_io;
    logic [14:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_timeout;
    logic [7:0]  rsp_rdata;
    logic [14:0] bus_a;
    logic        bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen;
    logic [7:0]  bus_d, bus_out;
    logic        bus_dir, bus_rdy;

    isa_bus_initiator #(.WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .nRESET(nRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_io(req_io),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .bus_a(bus_a), .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
        .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .bus_aen(bus_aen),
        .bus_d(bus_d), .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic        rv;
        logic [7:0]  rdata;
        logic        tmo;
        logic [14:0] a;
        logic [3:0]  strb;
        logic        aen;
        logic [7:0]  d;
    } exp_t;

    exp_t exp_cur;
    bit   chk_en = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    function automatic exp_t idle_exp();
        exp_t e;
        e       = '0;
        e.ready = 1'b1;
        e.strb  = 4'hF;
        e.aen   = 1'b1;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready",   32'(req_ready),   32'(exp_cur.ready));
            chk("rsp_valid",   32'(rsp_valid),   32'(exp_cur.rv));
            chk("rsp_rdata",   32'(rsp_rdata),   32'(exp_cur.rdata));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_cur.tmo));
            chk("bus_a",       32'(bus_a),       32'(exp_cur.a));
            chk("strobes",     32'({bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}), 32'(exp_cur.strb));
            chk("bus_aen",     32'(bus_aen),     32'(exp_cur.aen));
            chk("bus_d",       32'(bus_d),       32'(exp_cur.d));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            exp_cur   = idle_exp();
            req_valid = 1'b0;
            bus_rdy   = 1'b1;
        end
    endtask

    // Runs one bus cycle starting in a ready clock. w = clocks bus_rdy stays low after the
    // strobe count ends; noise keeps req_valid high with junk fields while busy.
    task automatic run_txn(input bit wr, input bit io, input logic [14:0] addr,
                           input logic [7:0] wd, input bit dir, input logic [7:0] bo,
                           input int w, input bit noise,
                           output int strb_low, output int lat, output int lead,
                           output logic [7:0] rd, output logic rtmo);
        exp_t tl[$];
        exp_t e0, e;
        int   nw;
        bit   tmo;
        bit   seen;
        logic [3:0] sel;
        nw  = (w > TO) ? TO : w;
        tmo = (w > TO);
        if (io && !wr)      sel = 4'b0111;
        else if (io && wr)  sel = 4'b1011;
        else if (!io && !wr) sel = 4'b1101;
        else                sel = 4'b1110;
        e0       = idle_exp();
        e0.ready = 1'b0;
        e0.aen   = 1'b0;
        e0.a     = addr;
        e0.d     = wr ? wd : 8'h00;
        for (int k = 0; k < S; k++) tl.push_back(e0);
        e = e0; e.strb = sel;
        for (int k = 0; k < T + nw; k++) tl.push_back(e);
        for (int k = 0; k < H; k++) tl.push_back(e0);
        e       = idle_exp();
        e.ready = 1'b0;
        e.rv    = 1'b1;
        e.tmo   = tmo;
        e.rdata = wr ? 8'h00 : ((tmo || !dir) ? 8'hFF : bo);
        tl.push_back(e);

        req_valid = 1'b1; req_write = wr; req_io = io; req_addr = addr; req_wdata = wd;
        bus_dir = dir; bus_out = bo; bus_rdy = 1'b1;
        exp_cur = idle_exp();
        strb_low = 0; lat = 0; lead = 0; rd = 8'h00; rtmo = 1'b0; seen = 1'b0;
        for (int k = 1; k <= tl.size(); k++) begin
            @(posedge clk); #1;
            exp_cur = tl[k-1];
            if (noise) begin
                req_valid = 1'b1;
                req_write = 1'($urandom);
                req_io    = 1'($urandom);
                req_addr  = 15'($urandom);
                req_wdata = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            bus_rdy = !((w > 0) && ((k >= S + T && k <= S + T + w - 1) || k <= S || k > S + T + nw));
            if ({bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l} != 4'hF) begin
                strb_low++;
                seen = 1'b1;
            end else if (!seen && !bus_aen) begin
                lead++;
            end
            if (rsp_valid && lat == 0) begin
                lat  = k;
                rd   = rsp_rdata;
                rtmo = rsp_timeout;
            end
        end
        @(posedge clk); #1;
        exp_cur = idle_exp();
        bus_rdy = 1'b1;
        if (!noise) req_valid = 1'b0;
    endtask

    int         sl, lat, lead;
    logic [7:0] rd;
    logic       rt;
    bit         rv_seen;

    initial begin
        nRESET = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
        req_addr = '0; req_wdata = '0; bus_out = '0; bus_dir = 1'b0; bus_rdy = 1'b1;
        exp_cur = idle_exp();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_aen",   32'(bus_aen),   32'd1);
        chk("reset_strb",  32'({bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}), 32'hF);
        chk("reset_rv",    32'(rsp_valid), 32'd0);
        nRESET = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // I/O write 0x3D8 <- 0x29
        run_txn(1, 1, 15'h3D8, 8'h29, 0, 8'h00, 0, 0, sl, lat, lead, rd, rt);
        chk("t1_iow_low", 32'(sl), 32'd4);
        chk("t1_latency", 32'(lat), 32'd7);
        chk("t1_aen_lead", 32'(lead), 32'd1);
        chk("t1_rdata", 32'(rd), 32'h00);
        idle(2);

        // I/O read 0x3DA, slave drives 0xF6
        run_txn(0, 1, 15'h3DA, 8'h00, 1, 8'hF6, 0, 0, sl, lat, lead, rd, rt);
        chk("t2_ior_low", 32'(sl), 32'd4);
        chk("t2_rdata", 32'(rd), 32'hF6);
        chk("t2_timeout", 32'(rt), 32'd0);
        idle(1);

        // I/O read 0x3D0, bus floats
        run_txn(0, 1, 15'h3D0, 8'h00, 0, 8'h5A, 0, 0, sl, lat, lead, rd, rt);
        chk("t3_rdata", 32'(rd), 32'hFF);
        idle(1);

        // Memory write with 3 wait clocks
        run_txn(1, 0, 15'h0123, 8'hA5, 0, 8'h00, 3, 0, sl, lat, lead, rd, rt);
        chk("t4_memw_low", 32'(sl), 32'd7);
        chk("t4_latency", 32'(lat), 32'd10);
        chk("t4_timeout", 32'(rt), 32'd0);
        idle(1);

        // Memory write, bus_rdy stuck low
        run_txn(1, 0, 15'h7FFF, 8'h3C, 0, 8'h00, 200, 0, sl, lat, lead, rd, rt);
        chk("t5_memw_low", 32'(sl), 32'd14);
        chk("t5_timeout", 32'(rt), 32'd1);
        chk("t5_rdata", 32'(rd), 32'h00);
        idle(1);

        // Memory read, bus_rdy stuck low: float data on timeout even with bus_dir high
        run_txn(0, 0, 15'h4000, 8'h00, 1, 8'h11, 200, 0, sl, lat, lead, rd, rt);
        chk("t6_memr_low", 32'(sl), 32'd14);
        chk("t6_rdata", 32'(rd), 32'hFF);
        chk("t6_timeout", 32'(rt), 32'd1);
        idle(1);

        // Memory read where ready arrives on the last allowed wait clock
        run_txn(0, 0, 15'h0042, 8'h00, 1, 8'h77, TO, 0, sl, lat, lead, rd, rt);
        chk("t7_memr_low", 32'(sl), 32'd14);
        chk("t7_rdata", 32'(rd), 32'h77);
        chk("t7_timeout", 32'(rt), 32'd0);
        idle(1);

        // Back-to-back CRTC index/data pair, req_valid held high
        run_txn(1, 1, 15'h3D4, 8'h0E, 0, 8'h00, 0, 1, sl, lat, lead, rd, rt);
        chk("t8a_latency", 32'(lat), 32'd7);
        run_txn(1, 1, 15'h3D5, 8'h12, 0, 8'h00, 0, 0, sl, lat, lead, rd, rt);
        chk("t8b_latency", 32'(lat), 32'd7);
        chk("t8b_iow_low", 32'(sl), 32'd4);
        idle(1);

        // Reset asserted in the middle of a read strobe
        req_valid = 1'b1; req_write = 1'b0; req_io = 1'b1; req_addr = 15'h3DA;
        bus_dir = 1'b1; bus_out = 8'hC3;
        @(posedge clk); #1;
        chk_en = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pre_ior", 32'(bus_ior_l), 32'd0);
        #2;
        nRESET = 1'b0;
        #1;
        chk("rst_strb", 32'({bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}), 32'hF);
        chk("rst_aen",   32'(bus_aen),   32'd1);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_a",     32'(bus_a),     32'd0);
        rv_seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid) rv_seen = 1'b1;
        end
        nRESET = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid) rv_seen = 1'b1;
        end
        chk("rst_no_rsp", 32'(rv_seen), 32'd0);
        exp_cur = idle_exp();
        chk_en  = 1'b1;

        run_txn(1, 1, 15'h3D9, 8'h07, 0, 8'h00, 0, 0, sl, lat, lead, rd, rt);
        chk("t9_latency", 32'(lat), 32'd7);
        chk("t9_iow_low", 32'(sl), 32'd4);
        idle(2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
